// File: rtl/pc_sequencer_pkg.sv
// =============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared constants, opcode and state encodings for pc_sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package pc_sequencer_pkg;

    localparam int c_PC_W       = 9;
    localparam int c_BANK_DEPTH = 8;
    localparam int c_DEPTH_W    = 4;

    localparam logic [c_DEPTH_W-1:0] c_MAX_DEPTH = c_DEPTH_W'(c_BANK_DEPTH - 1);

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JMP  = 3'd1,
        OP_JZ   = 3'd2,
        OP_JNZ  = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_HALT = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STEP  = 3'd1,
        S_PUSH  = 3'd2,
        S_SETC  = 3'd3,
        S_HALT  = 3'd4,
        S_FAULT = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/call_depth_tracker.sv
// =============================================================================
// Module      : call_depth_tracker
// Description : Saturating up/down counter mirroring the PC bank stack pointer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module call_depth_tracker
    import pc_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_push,
    input  logic                 i_pop,
    output logic [c_DEPTH_W-1:0] o_count,
    output logic                 o_at_max,
    output logic                 o_at_min
);

    logic [c_DEPTH_W-1:0] r_count;
    logic                 w_at_max;
    logic                 w_at_min;

    assign w_at_max = (r_count == c_MAX_DEPTH);
    assign w_at_min = (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_push && !i_pop && !w_at_max) begin
            r_count <= r_count + 1'b1;
        end else if (i_pop && !i_push && !w_at_min) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = w_at_max;
    assign o_at_min = w_at_min;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// =============================================================================
// Module      : pc_sequencer
// Description : Control-flow sequencer issuing one-hot strobes to the PC bank.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           op,
    input  logic [c_PC_W-1:0]    target,
    input  logic                 zero,
    input  logic                 pc_err,
    output logic                 pc_inc,
    output logic                 pc_ref_inc,
    output logic                 pc_ref_dec,
    output logic                 pc_set,
    output logic [c_PC_W-1:0]    pc_set_value,
    output logic                 done,
    output logic [c_DEPTH_W-1:0] depth,
    output logic                 halted,
    output logic                 fault
);

    state_e              r_state;
    state_e              w_next;
    op_e                 r_op;
    logic [c_PC_W-1:0]   r_target;
    logic                r_zero;

    logic                w_accept;
    logic                w_taken;
    logic                w_push;
    logic                w_pop;
    logic                w_at_max;
    logic                w_at_min;

    assign w_accept = instr_valid && (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= OP_NEXT;
            r_target <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op     <= op_e'(op);
                r_target <= target;
                r_zero   <= zero;
            end
        end
    end

    // Overflow/underflow are decided on the live op so no strobe ever leaves.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (pc_err) begin
                    w_next = S_FAULT;
                end else if (instr_valid) begin
                    case (op_e'(op))
                        OP_NEXT, OP_JMP,
                        OP_JZ, OP_JNZ: w_next = S_STEP;
                        OP_CALL:       w_next = w_at_max ? S_FAULT : S_STEP;
                        OP_RET:        w_next = w_at_min ? S_FAULT : S_STEP;
                        OP_HALT:       w_next = S_HALT;
                        default:       w_next = S_FAULT;
                    endcase
                end
            end
            S_STEP: begin
                if (pc_err)                w_next = S_FAULT;
                else if (r_op == OP_CALL)  w_next = S_PUSH;
                else                       w_next = S_IDLE;
            end
            S_PUSH:  w_next = pc_err ? S_FAULT : S_SETC;
            S_SETC:  w_next = pc_err ? S_FAULT : S_IDLE;
            S_HALT:  w_next = S_HALT;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FAULT;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_op)
            OP_JMP:  w_taken = 1'b1;
            OP_JZ:   w_taken = r_zero;
            OP_JNZ:  w_taken = !r_zero;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_inc     = 1'b0;
        pc_ref_inc = 1'b0;
        pc_ref_dec = 1'b0;
        pc_set     = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_STEP: begin
                case (r_op)
                    OP_CALL: pc_inc = 1'b1;
                    OP_RET: begin
                        pc_ref_dec = 1'b1;
                        done       = 1'b1;
                    end
                    default: begin
                        pc_set = w_taken;
                        pc_inc = !w_taken;
                        done   = 1'b1;
                    end
                endcase
            end
            S_PUSH: pc_ref_inc = 1'b1;
            S_SETC: begin
                pc_set = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_set_value = pc_set ? r_target : '0;
    assign instr_ready  = (r_state == S_IDLE);
    assign halted       = (r_state == S_HALT);
    assign fault        = (r_state == S_FAULT);

    // Depth moves at the end of the strobe cycle, in step with the bank pointer.
    assign w_push = (r_state == S_PUSH);
    assign w_pop  = (r_state == S_STEP) && (r_op == OP_RET);

    call_depth_tracker u_depth (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .o_count  (depth),
        .o_at_max (w_at_max),
        .o_at_min (w_at_min)
    );

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// =============================================================================
// Module      : tb_pc_sequencer
// Description : Directed scoreboard bench for pc_sequencer with a PC bank model.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] op = 3'd0;
    logic [8:0] target = 9'd0;
    logic       zero = 1'b0;
    logic       pc_err = 1'b0;
    logic       pc_inc, pc_ref_inc, pc_ref_dec, pc_set;
    logic [8:0] pc_set_value;
    logic       done;
    logic [3:0] depth;
    logic       halted, fault;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .op           (op),
        .target       (target),
        .zero         (zero),
        .pc_err       (pc_err),
        .pc_inc       (pc_inc),
        .pc_ref_inc   (pc_ref_inc),
        .pc_ref_dec   (pc_ref_dec),
        .pc_set       (pc_set),
        .pc_set_value (pc_set_value),
        .done         (done),
        .depth        (depth),
        .halted       (halted),
        .fault        (fault)
    );

    // Behavioural PC bank driven by the strobes
    logic [8:0] bank [8];
    logic [2:0] ptr;
    logic [8:0] pc_out;
    assign pc_out = bank[ptr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) bank[i] <= 9'd0;
            ptr <= 3'd0;
        end else if (pc_inc) begin
            bank[ptr] <= bank[ptr] + 9'd1;
        end else if (pc_ref_inc) begin
            ptr <= ptr + 3'd1;
        end else if (pc_ref_dec) begin
            ptr <= ptr - 3'd1;
        end else if (pc_set) begin
            bank[ptr] <= pc_set_value;
        end
    end

    // {inc,ref_inc,ref_dec,set, value, done, depth, ready, halted, fault}
    logic [20:0] obs;
    assign obs = {pc_inc, pc_ref_inc, pc_ref_dec, pc_set, pc_set_value,
                  done, depth, instr_ready, halted, fault};

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] INC  = 4'b1000;
    localparam logic [3:0] RINC = 4'b0100;
    localparam logic [3:0] RDEC = 4'b0010;
    localparam logic [3:0] SET  = 4'b0001;

    function automatic logic [20:0] mk(logic [3:0] s, logic [8:0] v, logic d,
                                       logic [3:0] dep, logic r, logic h, logic f);
        return {s, v, d, dep, r, h, f};
    endfunction

    logic [20:0] q[$];
    int          m_depth = 0;

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert ($countones({pc_inc, pc_ref_inc, pc_ref_dec, pc_set}) <= 1)
            else begin
                fails++;
                $error("FAIL onehot_strobes: observed %b required at most one set",
                       {pc_inc, pc_ref_inc, pc_ref_dec, pc_set});
            end
        end
    end

    task automatic drain(input string tag);
        logic [20:0] e;
        while (q.size() > 0) begin
            @(negedge clk);
            e = q.pop_front();
            total++;
            assert (obs === e)
            else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic check_pc(input string tag, input logic [8:0] e);
        total++;
        assert (pc_out === e)
        else begin
            fails++;
            $error("FAIL %s: pc_out observed %h expected %h", tag, pc_out, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        pc_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_depth = 0;
        q.push_back(mk(NONE, 9'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
        drain("reset_state");
    endtask

    task automatic accept(input logic [2:0] o, input logic [8:0] t, input logic z,
                          input string tag);
        int n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            total++;
            fails++;
            $error("FAIL %s_ready_timeout: observed instr_ready=0 expected 1", tag);
        end
        instr_valid = 1'b1;
        op = o;
        target = t;
        zero = z;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        op = 3'd0;
        target = 9'd0;
        zero = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [8:0] t, input logic z,
                         input string tag);
        logic [3:0] d;
        logic       tk;
        d = 4'(m_depth);
        accept(o, t, z, tag);
        case (op_e'(o))
            OP_NEXT, OP_JMP, OP_JZ, OP_JNZ: begin
                tk = (o == OP_JMP) || (o == OP_JZ && z) || (o == OP_JNZ && !z);
                q.push_back(mk(tk ? SET : INC, tk ? t : 9'd0, 1'b1, d, 1'b0, 1'b0, 1'b0));
                q.push_back(mk(NONE, 9'd0, 1'b0, d, 1'b1, 1'b0, 1'b0));
            end
            OP_CALL: begin
                if (m_depth == 7) begin
                    repeat (3) q.push_back(mk(NONE, 9'd0, 1'b0, d, 1'b0, 1'b0, 1'b1));
                end else begin
                    q.push_back(mk(INC,  9'd0, 1'b0, d, 1'b0, 1'b0, 1'b0));
                    q.push_back(mk(RINC, 9'd0, 1'b0, d, 1'b0, 1'b0, 1'b0));
                    q.push_back(mk(SET,  t,    1'b1, d + 4'd1, 1'b0, 1'b0, 1'b0));
                    q.push_back(mk(NONE, 9'd0, 1'b0, d + 4'd1, 1'b1, 1'b0, 1'b0));
                    m_depth++;
                end
            end
            OP_RET: begin
                if (m_depth == 0) begin
                    repeat (3) q.push_back(mk(NONE, 9'd0, 1'b0, d, 1'b0, 1'b0, 1'b1));
                end else begin
                    q.push_back(mk(RDEC, 9'd0, 1'b1, d, 1'b0, 1'b0, 1'b0));
                    q.push_back(mk(NONE, 9'd0, 1'b0, d - 4'd1, 1'b1, 1'b0, 1'b0));
                    m_depth--;
                end
            end
            OP_HALT: repeat (3) q.push_back(mk(NONE, 9'd0, 1'b0, d, 1'b0, 1'b1, 1'b0));
            default: repeat (3) q.push_back(mk(NONE, 9'd0, 1'b0, d, 1'b0, 1'b0, 1'b1));
        endcase
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();

        issue(OP_NEXT, 9'd0, 1'b0, "next1");
        check_pc("next1_pc", 9'd1);
        issue(OP_NEXT, 9'd0, 1'b0, "next2");
        issue(OP_NEXT, 9'd0, 1'b0, "next3");
        check_pc("next3_pc", 9'd3);

        issue(OP_CALL, 9'h100, 1'b0, "call");
        check_pc("call_pc", 9'h100);
        total++;
        assert (bank[0] === 9'd4)
        else begin
            fails++;
            $error("FAIL call_ret_addr: bank[0] observed %h expected %h", bank[0], 9'd4);
        end
        issue(OP_RET, 9'd0, 1'b0, "ret");
        check_pc("ret_pc", 9'd4);

        issue(OP_JZ,  9'h0A5, 1'b1, "jz_taken");
        check_pc("jz_taken_pc", 9'h0A5);
        issue(OP_JZ,  9'h0A5, 1'b0, "jz_not_taken");
        check_pc("jz_not_taken_pc", 9'h0A6);
        issue(OP_JNZ, 9'h1FF, 1'b0, "jnz_taken");
        issue(OP_NEXT, 9'd0, 1'b0, "wrap");
        check_pc("wrap_pc", 9'h000);
        issue(OP_JMP, 9'h055, 1'b1, "jmp");
        issue(OP_JNZ, 9'h010, 1'b1, "jnz_not_taken");
        check_pc("jnz_not_taken_pc", 9'h056);

        // Stack overflow
        do_reset();
        for (int i = 0; i < 7; i++) issue(OP_CALL, 9'(i + 8), 1'b0, "call_fill");
        issue(OP_CALL, 9'h001, 1'b0, "call_overflow");
        instr_valid = 1'b1;
        op = 3'd0;
        repeat (5) q.push_back(mk(NONE, 9'd0, 1'b0, 4'd7, 1'b0, 1'b0, 1'b1));
        drain("fault_sticky");
        instr_valid = 1'b0;

        do_reset();
        issue(OP_RET, 9'd0, 1'b0, "ret_underflow");

        do_reset();
        issue(3'd7, 9'h033, 1'b0, "reserved_op");

        // pc_err during the pc_inc cycle of a CALL
        do_reset();
        accept(OP_CALL, 9'h0F0, 1'b0, "err_call");
        q.push_back(mk(INC, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        drain("err_call_step");
        pc_err = 1'b1;
        q.push_back(mk(NONE, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        drain("err_call_fault");
        pc_err = 1'b0;
        repeat (2) q.push_back(mk(NONE, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1));
        drain("err_call_sticky");

        do_reset();
        issue(OP_HALT, 9'd0, 1'b0, "halt");
        instr_valid = 1'b1;
        op = 3'd0;
        repeat (20) q.push_back(mk(NONE, 9'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0));
        drain("halt_ignore");
        instr_valid = 1'b0;

        // Reset while the sequencer sits in S_PUSH
        do_reset();
        accept(OP_CALL, 9'h123, 1'b0, "rst_call");
        q.push_back(mk(INC,  9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(RINC, 9'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        drain("rst_call_pre");
        #1 rst = 1'b1;
        #1;
        total++;
        assert (obs === mk(NONE, 9'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0))
        else begin
            fails++;
            $error("FAIL rst_mid_call: observed %h expected %h", obs,
                   mk(NONE, 9'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst = 1'b0;
        m_depth = 0;
        q.push_back(mk(NONE, 9'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0));
        drain("rst_release");
        issue(OP_NEXT, 9'd0, 1'b0, "after_rst");
        check_pc("after_rst_pc", 9'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

`default_nettype wire
